// File: rtl/demux_1x3_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : demux_pkg
//  Description : Shared constants, slot state encoding and destination
//                decode helper for the registered 1-to-3 distributor.
//  Revision    : 1.0 - initial release
// ============================================================================
package demux_pkg;

  // Destination select encodings
  localparam logic [1:0] SEL_CH0  = 2'b00;
  localparam logic [1:0] SEL_CH1  = 2'b01;
  localparam logic [1:0] SEL_CH2  = 2'b10;
  localparam logic [1:0] SEL_DFLT = 2'b11;

  // Number of output slots
  localparam int NUM_CH = 3;

  // Per-slot occupancy state; a slot's valid output is simply ST_FULL
  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } slot_state_e;

  // Map a select code to a slot index. The spare code falls back to slot 0,
  // matching the read-side 3:1 channel select.
  function automatic logic [1:0] decode_target(input logic [1:0] sel);
    logic [1:0] idx;
    case (sel)
      SEL_CH1: idx = 2'd1;
      SEL_CH2: idx = 2'd2;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/demux_1x3_reg_if.sv
`default_nettype none
// ============================================================================
//  Module      : demux_1x3_reg_if
//  Description : Bundles the producer handshake and the three consumer slot
//                handshakes of the 1-to-3 distributor.
//                master : producer plus consumers (drives words and readies)
//                slave  : the distributor itself
//  Revision    : 1.0 - initial release
// ============================================================================
interface demux_1x3_reg_if #(
  parameter int W = 32
);

  // Producer side
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   select;
  logic [W-1:0] data_in;

  // Consumer side, one handshake per slot
  logic [W-1:0] ch_0;
  logic [W-1:0] ch_1;
  logic [W-1:0] ch_2;
  logic         valid_0;
  logic         valid_1;
  logic         valid_2;
  logic         ready_0;
  logic         ready_1;
  logic         ready_2;

  modport master (
    output in_valid, select, data_in, ready_0, ready_1, ready_2,
    input  in_ready, ch_0, ch_1, ch_2, valid_0, valid_1, valid_2
  );

  modport slave (
    input  in_valid, select, data_in, ready_0, ready_1, ready_2,
    output in_ready, ch_0, ch_1, ch_2, valid_0, valid_1, valid_2
  );

endinterface
`default_nettype wire

// File: rtl/demux_1x3_reg_slot.sv
`default_nettype none
// ============================================================================
//  Module      : demux_slot
//  Description : Single-entry output slot with valid/ready drain. A write in
//                the same cycle as a drain replaces the word and keeps the
//                slot full, giving one word per cycle throughput.
//  Revision    : 1.0 - initial release
// ============================================================================
module demux_slot
  import demux_pkg::*;
#(
  parameter int W = 32
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         wr_en,
  input  wire logic [W-1:0] wr_data,
  output logic      [W-1:0] out_data,
  output logic              out_valid,
  input  wire logic         out_ready,
  output logic              slot_free
);

  slot_state_e  state_q;
  slot_state_e  state_d;
  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  // State and data registers; reset drops any held word and clears the data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  // Next-state: load on write, empty on drain unless refilled the same cycle
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    case (state_q)
      ST_EMPTY: begin
        if (wr_en) begin
          state_d = ST_FULL;
          data_d  = wr_data;
        end
      end
      ST_FULL: begin
        if (wr_en) begin
          data_d = wr_data;
        end else if (out_ready) begin
          state_d = ST_EMPTY;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  assign out_data  = data_q;
  assign out_valid = (state_q == ST_FULL);
  // The slot can take a word if it is empty or its current word leaves now
  assign slot_free = !out_valid || out_ready;

endmodule
`default_nettype wire

// File: rtl/demux_1x3_reg.sv
`default_nettype none
// ============================================================================
//  Module      : demux_1x3_reg
//  Description : Registered 1-to-3 distributor. Routes a producer word into
//                one of three single-entry slots, each with its own
//                valid/ready handshake toward a consumer. Only the target
//                slot can hold off the producer.
//  Options     : DEMUX_BROADCAST_EN - when defined, select 2'b11 writes all
//                three slots at once and waits for all three to be free.
//                When undefined, 2'b11 routes to slot 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module demux_1x3_reg
  import demux_pkg::*;
#(
  parameter int W = 32
) (
  input  wire logic        clk,
  input  wire logic        rst,
  demux_1x3_reg_if.slave   bus
);

  logic [1:0]        w_tgt;
  logic              w_bcast;
  logic              w_accept;
  logic [NUM_CH-1:0] w_slot_free;
  logic [NUM_CH-1:0] w_slot_valid;
  logic [NUM_CH-1:0] w_out_ready;
  logic [NUM_CH-1:0] w_wr_en;
  logic [W-1:0]      w_slot_data [NUM_CH];

  assign w_out_ready = {bus.ready_2, bus.ready_1, bus.ready_0};
  assign w_tgt       = decode_target(bus.select);

`ifdef DEMUX_BROADCAST_EN
  assign w_bcast = (bus.select == SEL_DFLT);
`else
  assign w_bcast = 1'b0;
`endif

  // Ready toward the producer depends only on the addressed slot(s), never
  // on in_valid, so the producer may look at it before committing a word
  always_comb begin
    bus.in_ready = 1'b0;
    if (w_bcast) begin
      bus.in_ready = &w_slot_free;
    end else begin
      case (w_tgt)
        2'd1:    bus.in_ready = w_slot_free[1];
        2'd2:    bus.in_ready = w_slot_free[2];
        default: bus.in_ready = w_slot_free[0];
      endcase
    end
  end

  assign w_accept = bus.in_valid && bus.in_ready;

  // Write enables: the accepted word goes only to its addressed slot(s)
  always_comb begin
    w_wr_en = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      w_wr_en[n] = w_accept && (w_bcast || (w_tgt == 2'(n)));
    end
  end

  generate
    for (genvar n = 0; n < NUM_CH; n++) begin : g_slot
      demux_slot #(
        .W (W)
      ) u_slot (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (w_wr_en[n]),
        .wr_data   (bus.data_in),
        .out_data  (w_slot_data[n]),
        .out_valid (w_slot_valid[n]),
        .out_ready (w_out_ready[n]),
        .slot_free (w_slot_free[n])
      );
    end
  endgenerate

  assign bus.ch_0    = w_slot_data[0];
  assign bus.ch_1    = w_slot_data[1];
  assign bus.ch_2    = w_slot_data[2];
  assign bus.valid_0 = w_slot_valid[0];
  assign bus.valid_1 = w_slot_valid[1];
  assign bus.valid_2 = w_slot_valid[2];

endmodule
`default_nettype wire
